tx_pkt_queue: RTL and testbench

Transmit-side packet descriptor queue for the MAC, on the user clock. User logic pushes 14-bit descriptors (frame length/buffer index) into a small synchronous FIFO. A scheduler FSM presents one descriptor at a time to the MAC transmit engine with a req/ack handshake, waits for frame completion, then enforces a programmable inter-frame gap before presenting the next one. It sits between the user packet builder and the MAC TX engine.

---
 rtl/tx_pkt_pkg.sv | 22 ++
 rtl/tx_pkt_fifo_sync.sv | 93 +++++++++
 rtl/tx_pkt_queue.sv | 152 +++++++++++++++
 tb/tb_tx_pkt_queue.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkt_pkg.sv
// Shared definitions for the transmit packet descriptor queue.
// Holds the scheduler state encoding and default sizing constants.
// The MAC TX engine imports the same package so both sides agree on them.
//   TX_DESC_WIDTH      : descriptor width in bits
//   TX_FIFO_DEPTH_LOG2 : log2 of the descriptor queue depth
//   TX_IFG_CYCLES      : default inter-frame gap in usr_clk cycles
//   tx_state_e         : scheduler FSM states, also visible on dbg_state
package tx_pkt_pkg;

    localparam int TX_DESC_WIDTH      = 14;
    localparam int TX_FIFO_DEPTH_LOG2 = 4;
    localparam int TX_IFG_CYCLES      = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_BUSY    = 3'd3,
        ST_GAP     = 3'd4
    } tx_state_e;

endpackage

// File: rtl/tx_pkt_fifo_sync.sv
// Single-clock descriptor FIFO with a synchronous flush.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_flush         : clears pointers, level and overflow; a push in the same cycle is dropped
//   i_push, i_wdata : push strobe and data; ignored while full (sets overflow)
//   i_pop           : pop strobe; o_rdata holds the popped word from the next cycle on
//   o_full, o_empty : occupancy flags derived from the registered level
//   o_level         : current occupancy, 0 .. 2**DEPTH_LOG2
//   o_overflow      : sticky, set when a push is dropped because the FIFO was full
module tx_pkt_fifo_sync
    import tx_pkt_pkg::*;
#(
    parameter int WIDTH      = TX_DESC_WIDTH,
    parameter int DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic [WIDTH-1:0]      r_rdata;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == (DEPTH_LOG2+1)'(DEPTH));
    assign w_empty = (r_level == '0);
    // Full is judged on the registered level, so a push and a pop in the
    // same cycle while full still drops the push.
    assign w_push  = i_push & ~w_full & ~i_flush;
    assign w_pop   = i_pop & ~w_empty & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rdata  <= r_mem[r_rd_ptr];
            end
            if (i_push && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rdata    = r_rdata;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_level    = r_level;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tx_pkt_queue.sv
// Transmit packet descriptor queue: FIFO of descriptors plus a scheduler
// that hands them one at a time to the MAC TX engine and spaces frames
// with an inter-frame gap.
// Ports:
//   usr_clk, reset_n      : clock, asynchronous active-low reset
//   we, din               : descriptor push
//   flush                 : clears queued descriptors and overflow; drops an unacked presentation
//   fifo_full, fifo_empty : queue occupancy flags
//   level                 : queue occupancy
//   overflow              : sticky dropped-push flag
//   tx_req, tx_desc       : descriptor offered to the MAC; tx_desc is stable while tx_req is high
//   tx_ack                : MAC took tx_desc (one-cycle pulse, honoured in PRESENT only)
//   tx_done               : MAC finished the frame (one-cycle pulse, honoured in BUSY,
//                           or together with tx_ack in PRESENT)
//   pkt_count             : frames completed, wraps at 16 bits
//   dbg_state             : current scheduler state (tx_state_e encoding)
// Handshake: tx_req rises with tx_desc valid and both hold until the cycle
// tx_ack is seen; tx_req drops on the following edge. tx_done then marks
// the end of the frame.
module tx_pkt_queue
    import tx_pkt_pkg::*;
#(
    parameter int WIDTH      = TX_DESC_WIDTH,
    parameter int DEPTH_LOG2 = TX_FIFO_DEPTH_LOG2,
    parameter int IFG_CYCLES = TX_IFG_CYCLES
) (
    input  logic                  usr_clk,
    input  logic                  reset_n,
    input  logic                  we,
    input  logic [WIDTH-1:0]      din,
    input  logic                  flush,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow,
    output logic                  tx_req,
    output logic [WIDTH-1:0]      tx_desc,
    input  logic                  tx_ack,
    input  logic                  tx_done,
    output logic [15:0]           pkt_count,
    output logic [2:0]            dbg_state
);

    // The pop happens in the last idle cycle of the gap, and LOAD adds one
    // more cycle, so GAP itself lasts IFG_CYCLES-1 cycles. That places the
    // next tx_req IFG_CYCLES+2 cycles after tx_done. Gaps below 2 cycles
    // skip GAP entirely.
    localparam int            GAP_W     = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES >= 2) ? IFG_CYCLES - 2 : 0);
    localparam tx_state_e     DONE_NEXT = (IFG_CYCLES >= 2) ? ST_GAP : ST_IDLE;

    tx_state_e         r_state;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic              r_tx_req;
    logic [WIDTH-1:0]  r_tx_desc;
    logic [15:0]       r_pkt_count;

    logic [WIDTH-1:0]  w_fifo_rdata;
    logic              w_fifo_empty;
    logic              w_pop;

    assign w_pop = (r_state == ST_IDLE) && !w_fifo_empty && !flush;

    tx_pkt_fifo_sync #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .i_clk      (usr_clk),
        .i_rst_n    (reset_n),
        .i_flush    (flush),
        .i_push     (we),
        .i_wdata    (din),
        .i_pop      (w_pop),
        .o_rdata    (w_fifo_rdata),
        .o_full     (fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (level),
        .o_overflow (overflow)
    );

    always_ff @(posedge usr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gap_cnt   <= '0;
            r_tx_req    <= 1'b0;
            r_tx_desc   <= '0;
            r_pkt_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (flush) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_tx_desc <= w_fifo_rdata;
                        r_tx_req  <= 1'b1;
                        r_state   <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    // A flush discards the offered descriptor even if the
                    // MAC acks in the same cycle.
                    if (flush) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (tx_ack) begin
                        r_tx_req <= 1'b0;
                        if (tx_done) begin
                            r_pkt_count <= r_pkt_count + 16'd1;
                            r_gap_cnt   <= '0;
                            r_state     <= DONE_NEXT;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // A frame in flight cannot be aborted, so flush is ignored here.
                    if (tx_done) begin
                        r_pkt_count <= r_pkt_count + 16'd1;
                        r_gap_cnt   <= '0;
                        r_state     <= DONE_NEXT;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_empty = w_fifo_empty;
    assign tx_req     = r_tx_req;
    assign tx_desc    = r_tx_desc;
    assign pkt_count  = r_pkt_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_tx_pkt_queue.sv
// Self-checking bench for tx_pkt_queue: a per-cycle vector table for the
// single-frame path, then directed sequences for the multi-cycle cases.
module tb_tx_pkt_queue;
    import tx_pkt_pkg::*;

    localparam int W   = 14;
    localparam int DL  = 4;
    localparam int IFG = 12;

    logic          usr_clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          we      = 1'b0;
    logic [W-1:0]  din     = '0;
    logic          flush   = 1'b0;
    logic          tx_ack  = 1'b0;
    logic          tx_done = 1'b0;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DL:0]   level;
    logic          overflow;
    logic          tx_req;
    logic [W-1:0]  tx_desc;
    logic [15:0]   pkt_count;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic          we;
        logic [W-1:0]  din;
        logic          flush;
        logic          ack;
        logic          done;
        logic          exp_req;
        logic [W-1:0]  exp_desc;
        logic [DL:0]   exp_level;
        logic [2:0]    exp_state;
        logic [15:0]   exp_cnt;
    } vec_t;

    vec_t vecs[$];

    tx_pkt_queue #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DL),
        .IFG_CYCLES (IFG)
    ) dut (
        .usr_clk    (usr_clk),
        .reset_n    (reset_n),
        .we         (we),
        .din        (din),
        .flush      (flush),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .overflow   (overflow),
        .tx_req     (tx_req),
        .tx_desc    (tx_desc),
        .tx_ack     (tx_ack),
        .tx_done    (tx_done),
        .pkt_count  (pkt_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 usr_clk = ~usr_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached (checks %0d errors %0d)", checks, errors);
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        flush   = 1'b0;
        tx_ack  = 1'b0;
        tx_done = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        din     = '0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic push(input logic [W-1:0] d);
        we  = 1'b1;
        din = d;
        step();
        we  = 1'b0;
    endtask

    task automatic ack_frame();
        tx_ack = 1'b1;
        step();
        tx_ack = 1'b0;
    endtask

    task automatic done_frame();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (tx_req !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        chk(name, 32'(tx_req), 32'd1);
    endtask

    // Steps n cycles and checks that tx_req never rose.
    task automatic expect_no_req(input string name, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            seen = seen | tx_req;
        end
        chk(name, 32'(seen), 32'd0);
    endtask

    function automatic void add_vec(input logic v_we, input logic [W-1:0] v_din,
                                    input logic v_ack, input logic v_done,
                                    input logic e_req, input logic [W-1:0] e_desc,
                                    input logic [DL:0] e_level, input tx_state_e e_state,
                                    input logic [15:0] e_cnt);
        vec_t v;
        v.we        = v_we;
        v.din       = v_din;
        v.flush     = 1'b0;
        v.ack       = v_ack;
        v.done      = v_done;
        v.exp_req   = e_req;
        v.exp_desc  = e_desc;
        v.exp_level = e_level;
        v.exp_state = e_state;
        v.exp_cnt   = e_cnt;
        vecs.push_back(v);
    endfunction

    // ---------------- test ----------------
    initial begin
        int n;

        // Each row: inputs for one cycle, expected outputs after that edge.
        add_vec(1, 14'h0123, 0, 0, 0, 14'h0000, 1, ST_IDLE,    0);
        add_vec(0, 14'h0000, 0, 0, 0, 14'h0000, 0, ST_LOAD,    0);
        add_vec(0, 14'h0000, 0, 0, 1, 14'h0123, 0, ST_PRESENT, 0);
        for (int i = 0; i < 5; i++)
            add_vec(0, 14'h0000, 0, 0, 1, 14'h0123, 0, ST_PRESENT, 0);
        add_vec(0, 14'h0000, 1, 0, 0, 14'h0123, 0, ST_BUSY,    0);
        add_vec(0, 14'h0000, 0, 1, 0, 14'h0123, 0, ST_GAP,     1);
        for (int i = 0; i < IFG - 2; i++)
            add_vec(0, 14'h0000, 0, 0, 0, 14'h0123, 0, ST_GAP, 1);
        add_vec(0, 14'h0000, 0, 0, 0, 14'h0123, 0, ST_IDLE,    1);
        add_vec(0, 14'h0000, 0, 1, 0, 14'h0123, 0, ST_IDLE,    1);
        add_vec(0, 14'h0000, 1, 0, 0, 14'h0123, 0, ST_IDLE,    1);

        // Reset values
        do_reset();
        chk("rst_empty",   32'(fifo_empty), 32'd1);
        chk("rst_full",    32'(fifo_full),  32'd0);
        chk("rst_level",   32'(level),      32'd0);
        chk("rst_ovf",     32'(overflow),   32'd0);
        chk("rst_req",     32'(tx_req),     32'd0);
        chk("rst_desc",    32'(tx_desc),    32'd0);
        chk("rst_cnt",     32'(pkt_count),  32'd0);
        chk("rst_state",   32'(dbg_state),  32'(ST_IDLE));

        // Single frame, per-cycle table
        foreach (vecs[i]) begin
            we      = vecs[i].we;
            din     = vecs[i].din;
            flush   = vecs[i].flush;
            tx_ack  = vecs[i].ack;
            tx_done = vecs[i].done;
            step();
            idle_inputs();
            chk($sformatf("vec%0d_req", i),   32'(tx_req),    32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_desc", i),  32'(tx_desc),   32'(vecs[i].exp_desc));
            chk($sformatf("vec%0d_level", i), 32'(level),     32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_state", i), 32'(dbg_state), 32'(vecs[i].exp_state));
            chk($sformatf("vec%0d_cnt", i),   32'(pkt_count), 32'(vecs[i].exp_cnt));
        end

        // Three frames: order and inter-frame gap
        do_reset();
        exp_q = {};
        for (int i = 0; i < 3; i++) begin
            push(14'(14'h0A1 + 14'h011 * i));
            exp_q.push_back(14'(14'h0A1 + 14'h011 * i));
        end
        for (int f = 0; f < 3; f++) begin
            wait_req("s2_req");
            chk("s2_desc", 32'(tx_desc), 32'(exp_q.pop_front()));
            ack_frame();
            chk("s2_req_drop", 32'(tx_req), 32'd0);
            repeat (9) step();
            done_frame();
            if (f < 2) begin
                n = 1;
                while (tx_req !== 1'b1 && n < 64) begin
                    step();
                    n++;
                end
                chk("s2_ifg_gap", 32'(n), 32'(IFG + 2));
            end
        end
        repeat (IFG + 2) step();
        chk("s2_cnt",   32'(pkt_count), 32'd3);
        chk("s2_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("s2_req",   32'(tx_req),    32'd0);

        // Fill while the scheduler is stalled, overflow, then drain
        do_reset();
        exp_q = {};
        push(14'h3A5);
        wait_req("s3_first_req");
        chk("s3_first_desc", 32'(tx_desc), 32'h3A5);
        for (int i = 0; i < 17; i++) begin
            push(14'(14'h100 + i));
            if (i < 16) exp_q.push_back(14'(14'h100 + i));
        end
        chk("s3_full",  32'(fifo_full),  32'd1);
        chk("s3_level", 32'(level),      32'd16);
        chk("s3_ovf",   32'(overflow),   32'd1);
        chk("s3_empty", 32'(fifo_empty), 32'd0);
        ack_frame();
        repeat (3) step();
        done_frame();
        repeat (IFG - 1) step();
        chk("s3_idle_pop", 32'(dbg_state), 32'(ST_IDLE));
        // Push while full in the same cycle as the pop: must be dropped
        push(14'h3FF);
        chk("s3_pushpop_level", 32'(level), 32'd15);
        chk("s3_pushpop_state", 32'(dbg_state), 32'(ST_LOAD));
        for (int i = 0; i < 16; i++) begin
            wait_req("s3_drain_req");
            chk("s3_drain_desc", 32'(tx_desc), 32'(exp_q.pop_front()));
            ack_frame();
            done_frame();
        end
        expect_no_req("s3_no_extra", 40);
        chk("s3_end_empty", 32'(fifo_empty), 32'd1);
        chk("s3_end_cnt",   32'(pkt_count),  32'd17);
        chk("s3_ovf_sticky", 32'(overflow),  32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s3_flush_ovf", 32'(overflow), 32'd0);

        // ack and done together, then stray pulses in IDLE
        do_reset();
        push(14'h055);
        wait_req("s4_req");
        tx_ack  = 1'b1;
        tx_done = 1'b1;
        step();
        idle_inputs();
        chk("s4_state_gap", 32'(dbg_state), 32'(ST_GAP));
        chk("s4_cnt",       32'(pkt_count), 32'd1);
        chk("s4_req",       32'(tx_req),    32'd0);
        repeat (IFG - 1) step();
        chk("s4_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        done_frame();
        chk("s4_stray_done", 32'(pkt_count), 32'd1);
        ack_frame();
        chk("s4_stray_ack", 32'(dbg_state), 32'(ST_IDLE));

        // flush while PRESENT, then flush while BUSY
        do_reset();
        for (int i = 0; i < 5; i++) push(14'(14'h200 + i));
        wait_req("s5_req");
        chk("s5_desc",  32'(tx_desc), 32'h200);
        chk("s5_level", 32'(level),   32'd4);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s5_fl_req",   32'(tx_req),     32'd0);
        chk("s5_fl_level", 32'(level),      32'd0);
        chk("s5_fl_empty", 32'(fifo_empty), 32'd1);
        chk("s5_fl_state", 32'(dbg_state),  32'(ST_IDLE));
        expect_no_req("s5_fl_quiet", 5);
        push(14'h2B0);
        push(14'h2B1);
        wait_req("s5_b_req");
        chk("s5_b_desc", 32'(tx_desc), 32'h2B0);
        ack_frame();
        chk("s5_b_state", 32'(dbg_state), 32'(ST_BUSY));
        chk("s5_b_level", 32'(level),     32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("s5_bf_state", 32'(dbg_state), 32'(ST_BUSY));
        chk("s5_bf_level", 32'(level),     32'd0);
        repeat (3) step();
        chk("s5_bf_wait", 32'(dbg_state), 32'(ST_BUSY));
        done_frame();
        chk("s5_bf_cnt",   32'(pkt_count), 32'd1);
        chk("s5_bf_gap",   32'(dbg_state), 32'(ST_GAP));
        expect_no_req("s5_bf_quiet", 40);

        // Asynchronous reset mid-BUSY
        do_reset();
        for (int i = 0; i < 7; i++) push(14'(14'h300 + i));
        wait_req("s6_req0");
        ack_frame();
        done_frame();
        wait_req("s6_req1");
        chk("s6_desc1", 32'(tx_desc), 32'h301);
        ack_frame();
        chk("s6_state", 32'(dbg_state), 32'(ST_BUSY));
        chk("s6_level", 32'(level),     32'd5);
        chk("s6_cnt",   32'(pkt_count), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("s6_ar_req",   32'(tx_req),     32'd0);
        chk("s6_ar_desc",  32'(tx_desc),    32'd0);
        chk("s6_ar_level", 32'(level),      32'd0);
        chk("s6_ar_empty", 32'(fifo_empty), 32'd1);
        chk("s6_ar_full",  32'(fifo_full),  32'd0);
        chk("s6_ar_ovf",   32'(overflow),   32'd0);
        chk("s6_ar_cnt",   32'(pkt_count),  32'd0);
        chk("s6_ar_state", 32'(dbg_state),  32'(ST_IDLE));
        step();
        step();
        reset_n = 1'b1;
        step();
        push(14'h2AA);
        chk("s6_new_c1", 32'(tx_req), 32'd0);
        step();
        chk("s6_new_c2", 32'(tx_req), 32'd0);
        step();
        chk("s6_new_req",  32'(tx_req),  32'd1);
        chk("s6_new_desc", 32'(tx_desc), 32'h2AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
